// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared types for the stack command front-end and its response FIFO.
//   op_t           : command opcode (OP_PUSH = 0, OP_POP = 1)
//   rsp_t          : one response entry {op, err, data}
//   MEM_RD_LAT_MAX : largest supported SRAM read latency
//   rsp_make       : builds a response entry; data is forced to zero unless
//                    the entry is a successful pop
// No ports (package).
// -----------------------------------------------------------------------------
package stack_pkg;

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_t;

    localparam int MEM_RD_LAT_MAX = 2;

    // Packages cannot be parameterised, so the response data field is sized
    // for the widest supported entry; narrower instances zero-extend and the
    // constant upper bits fall away in synthesis.
    localparam int RSP_DATA_W_MAX = 64;

    typedef struct packed {
        op_t                       op;
        logic                      err;
        logic [RSP_DATA_W_MAX-1:0] data;
    } rsp_t;

    function automatic rsp_t rsp_make(op_t op, logic err,
                                      logic [RSP_DATA_W_MAX-1:0] rdata);
        rsp_t r;
        r.op   = op;
        r.err  = err;
        r.data = (op == OP_POP && !err) ? rdata : '0;
        return r;
    endfunction

endpackage

// File: rtl/stack_cmd_frontend_if.sv
// -----------------------------------------------------------------------------
// stack_cmd_frontend_if
// Bundles every non-clock/reset signal of stack_cmd_frontend. Signal names keep
// the i_/o_ prefixes as seen from the front-end itself.
//   command stream : i_cmd_vld, i_cmd_op, i_cmd_data, o_cmd_rdy
//   response stream: o_rsp_vld, o_rsp_op, o_rsp_err, o_rsp_data, i_rsp_rdy
//   controller     : o_cntrl_push, o_cntrl_pop, i_cntrl_full_w, i_cntrl_empty_w
//   SRAM           : o_mem_wdata, i_mem_rdata
// Modports: slave = the front-end, master = its surroundings.
// -----------------------------------------------------------------------------
interface stack_cmd_frontend_if #(
    parameter int W = 32
);
    import stack_pkg::*;

    logic         i_cmd_vld;
    op_t          i_cmd_op;
    logic [W-1:0] i_cmd_data;
    logic         o_cmd_rdy;

    logic         o_rsp_vld;
    op_t          o_rsp_op;
    logic         o_rsp_err;
    logic [W-1:0] o_rsp_data;
    logic         i_rsp_rdy;

    logic         o_cntrl_push;
    logic         o_cntrl_pop;
    logic         i_cntrl_full_w;
    logic         i_cntrl_empty_w;

    logic [W-1:0] o_mem_wdata;
    logic [W-1:0] i_mem_rdata;

    modport slave (
        input  i_cmd_vld, i_cmd_op, i_cmd_data, i_rsp_rdy,
               i_cntrl_full_w, i_cntrl_empty_w, i_mem_rdata,
        output o_cmd_rdy, o_rsp_vld, o_rsp_op, o_rsp_err, o_rsp_data,
               o_cntrl_push, o_cntrl_pop, o_mem_wdata
    );

    modport master (
        output i_cmd_vld, i_cmd_op, i_cmd_data, i_rsp_rdy,
               i_cntrl_full_w, i_cntrl_empty_w, i_mem_rdata,
        input  o_cmd_rdy, o_rsp_vld, o_rsp_op, o_rsp_err, o_rsp_data,
               o_cntrl_push, o_cntrl_pop, o_mem_wdata
    );

endinterface

// File: rtl/stack_rsp_fifo.sv
// -----------------------------------------------------------------------------
// stack_rsp_fifo
// DEPTH-entry FIFO of rsp_t with registered outputs and valid/ready read side.
// The head entry lives in the output register; the remaining DEPTH-1 entries
// sit in a small ring behind it.
//   clk, arst_n : clock, asynchronous active-low reset
//   wr, wdata   : write strobe and entry (never asserted into a full FIFO)
//   vld, rdata  : registered head valid / head entry
//   rdy         : consumer ready; vld & rdy dequeues the head
//   cnt         : total entries held, including the head
// -----------------------------------------------------------------------------
module stack_rsp_fifo
    import stack_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         wr,
    input  rsp_t                         wdata,
    output logic                         vld,
    output rsp_t                         rdata,
    input  logic                         rdy,
    output logic [$clog2(DEPTH+1)-1:0]   cnt
);

    localparam int RING = DEPTH - 1;
    localparam int PW   = (RING > 1) ? $clog2(RING) : 1;
    localparam int CW   = $clog2(DEPTH + 1);

    rsp_t          ring [RING];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] ring_cnt;

    logic deq, refill, pop_ring, bypass, push_ring;

    function automatic logic [PW-1:0] ptr_next(logic [PW-1:0] p);
        return (p == PW'(RING - 1)) ? '0 : p + 1'b1;
    endfunction

    // The head register is refilled whenever it is empty or being consumed.
    // An incoming entry goes straight to the head only when nothing older is
    // waiting in the ring; otherwise it queues behind.
    assign deq       = vld & rdy;
    assign refill    = ~vld | deq;
    assign pop_ring  = refill & (ring_cnt != '0);
    assign bypass    = refill & (ring_cnt == '0) & wr;
    assign push_ring = wr & ~bypass;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vld      <= 1'b0;
            rdata    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ring_cnt <= '0;
            cnt      <= '0;
        end else begin
            if (pop_ring) begin
                vld    <= 1'b1;
                rdata  <= ring[rd_ptr];
                rd_ptr <= ptr_next(rd_ptr);
            end else if (bypass) begin
                vld    <= 1'b1;
                rdata  <= wdata;
            end else if (refill) begin
                vld    <= 1'b0;
            end

            if (push_ring) begin
                wr_ptr <= ptr_next(wr_ptr);
            end

            case ({push_ring, pop_ring})
                2'b10:   ring_cnt <= ring_cnt + 1'b1;
                2'b01:   ring_cnt <= ring_cnt - 1'b1;
                default: ring_cnt <= ring_cnt;
            endcase

            case ({wr, deq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Ring storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        if (push_ring) begin
            ring[wr_ptr] <= wdata;
        end
    end

    // The parent's credit scheme must make an overflowing write impossible.
    always @(posedge clk) begin
        if (arst_n) begin
            assert (!(wr && !deq && cnt == CW'(DEPTH)));
        end
    end

endmodule

// File: rtl/stack_cmd_frontend.sv
// -----------------------------------------------------------------------------
// stack_cmd_frontend
// Command front-end upstream of a stack controller and its SRAM. Accepts
// PUSH/POP commands, issues push/pop strobes, captures SRAM read data after
// MEM_RD_LAT cycles and returns one in-order response per command.
//   clk    : clock
//   arst_n : asynchronous active-low reset
//   bus    : stack_cmd_frontend_if.slave (command, response, controller and
//            SRAM signals)
// Parameters: N (stack entries), W (data width), MEM_RD_LAT (1..2),
//             RSP_DEPTH (response FIFO depth, >= MEM_RD_LAT+2).
// -----------------------------------------------------------------------------
module stack_cmd_frontend
    import stack_pkg::*;
#(
    parameter int N          = 4,
    parameter int W          = 32,
    parameter int MEM_RD_LAT = 1,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 arst_n,
    stack_cmd_frontend_if.slave  bus
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic          full_r, empty_r;
    logic [CW-1:0] inflight;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   credit_used;

    logic acc, is_push, push_ok, pop_ok, err;

    logic vld_p [MEM_RD_LAT];
    op_t  op_p  [MEM_RD_LAT];
    logic err_p [MEM_RD_LAT];

    logic pipe_exit;
    rsp_t fifo_wdata, fifo_rdata;
    logic fifo_vld;
    logic unused_rsp_hi;

    // Credit: every accepted command owns a FIFO slot until its response is
    // dequeued, so the FIFO can never overflow. Registered counters only.
    assign credit_used   = {1'b0, inflight} + {1'b0, fifo_cnt};
    assign bus.o_cmd_rdy = credit_used < (CW+1)'(RSP_DEPTH);

    assign acc     = bus.i_cmd_vld & bus.o_cmd_rdy;
    assign is_push = (bus.i_cmd_op == OP_PUSH);
    assign push_ok = acc &  is_push & ~full_r;
    assign pop_ok  = acc & ~is_push & ~empty_r;
    assign err     = acc & ((is_push & full_r) | (~is_push & empty_r));

    assign bus.o_cntrl_push = push_ok;
    assign bus.o_cntrl_pop  = pop_ok;
    assign bus.o_mem_wdata  = bus.i_cmd_data;

    // Flags mirror the controller's next state, sampled only when it moves.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else if (push_ok || pop_ok) begin
            full_r  <= bus.i_cntrl_full_w;
            empty_r <= bus.i_cntrl_empty_w;
        end
    end

    // ---- stage p0 .. p(MEM_RD_LAT-1): align command with SRAM read data ----
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < MEM_RD_LAT; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0] <= acc;
            for (int i = 1; i < MEM_RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        op_p[0]  <= bus.i_cmd_op;
        err_p[0] <= err;
        for (int i = 1; i < MEM_RD_LAT; i++) begin
            op_p[i]  <= op_p[i-1];
            err_p[i] <= err_p[i-1];
        end
    end

    // ---- pipeline exit: read data is valid now, write the response ----
    assign pipe_exit  = vld_p[MEM_RD_LAT-1];
    assign fifo_wdata = rsp_make(op_p[MEM_RD_LAT-1], err_p[MEM_RD_LAT-1],
                                 RSP_DATA_W_MAX'(bus.i_mem_rdata));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            inflight <= '0;
        end else begin
            case ({acc, pipe_exit})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    stack_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .wr     (pipe_exit),
        .wdata  (fifo_wdata),
        .vld    (fifo_vld),
        .rdata  (fifo_rdata),
        .rdy    (bus.i_rsp_rdy),
        .cnt    (fifo_cnt)
    );

    assign bus.o_rsp_vld  = fifo_vld;
    assign bus.o_rsp_op   = fifo_rdata.op;
    assign bus.o_rsp_err  = fifo_rdata.err;
    assign bus.o_rsp_data = fifo_rdata.data[W-1:0];

    // Bits above W are always zero; folded here so they are not left dangling.
    assign unused_rsp_hi = ^fifo_rdata.data;

    // Configuration sanity.
    always @(posedge clk) begin
        assert (N >= 1 && MEM_RD_LAT >= 1 && MEM_RD_LAT <= MEM_RD_LAT_MAX &&
                RSP_DEPTH >= MEM_RD_LAT + 2 && W <= RSP_DATA_W_MAX);
    end

endmodule

// File: tb/tb_stack_cmd_frontend.sv
// -----------------------------------------------------------------------------
// tb_stack_cmd_frontend
// Directed bench for stack_cmd_frontend with a stack controller + SRAM model
// attached. A reference model (plain stack and response queue) is compared
// with the DUT on every negedge; hand-computed expectations pin each scenario.
// -----------------------------------------------------------------------------
module tb_stack_cmd_frontend;
    import stack_pkg::*;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    stack_cmd_frontend_if #(.W(W)) bus ();

    stack_cmd_frontend #(
        .N(N), .W(W), .MEM_RD_LAT(LAT), .RSP_DEPTH(DEPTH)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    // ---------------- stack controller + SRAM environment ----------------
    int           sp;
    int           sp_nxt;
    logic [W-1:0] sram [N];

    always_comb begin
        sp_nxt = sp + (bus.o_cntrl_push ? 1 : 0) - (bus.o_cntrl_pop ? 1 : 0);
    end
    assign bus.i_cntrl_full_w  = (sp_nxt == N);
    assign bus.i_cntrl_empty_w = (sp_nxt == 0);

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sp              <= 0;
            bus.i_mem_rdata <= '0;
        end else if (bus.o_cntrl_push) begin
            if (sp < N) sram[sp] <= bus.o_mem_wdata;
            sp <= sp + 1;
        end else if (bus.o_cntrl_pop) begin
            if (sp > 0) bus.i_mem_rdata <= sram[sp-1];
            sp <= sp - 1;
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        op_t          op;
        logic         err;
        logic [W-1:0] data;
        int           acc_cyc;
    } exp_t;

    typedef struct {
        op_t          op;
        logic         err;
        logic [W-1:0] data;
        int           lat;
        int           deq_cyc;
    } log_t;

    exp_t         exp_q [$];
    log_t         rsp_log [$];
    logic [W-1:0] stk [$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int push_cnt = 0;
    int pop_cnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        log_t l;
        logic ev, acc, epush, epop;
        cyc++;
        if (!arst_n) begin
            exp_q.delete();
            stk.delete();
        end else begin
            // Credit: outstanding = accepted but not yet dequeued.
            chk("cmd_rdy", bus.o_cmd_rdy, exp_q.size() < DEPTH);
            ev = (exp_q.size() > 0) && (exp_q[0].acc_cyc + LAT + 1 <= cyc);
            chk("rsp_vld", bus.o_rsp_vld, ev);
            if (ev && bus.o_rsp_vld) begin
                chk("rsp_op",   bus.o_rsp_op,   exp_q[0].op);
                chk("rsp_err",  bus.o_rsp_err,  exp_q[0].err);
                chk("rsp_data", bus.o_rsp_data, exp_q[0].data);
            end

            acc   = bus.i_cmd_vld && bus.o_cmd_rdy;
            epush = 1'b0;
            epop  = 1'b0;
            e.op = OP_PUSH; e.err = 1'b0; e.data = '0; e.acc_cyc = cyc;
            if (acc) begin
                e.op = bus.i_cmd_op;
                if (e.op == OP_PUSH) begin
                    if (stk.size() >= N) e.err = 1'b1;
                    else begin epush = 1'b1; stk.push_back(bus.i_cmd_data); end
                end else begin
                    if (stk.size() == 0) e.err = 1'b1;
                    else begin epop = 1'b1; e.data = stk.pop_back(); end
                end
            end
            chk("cntrl_push", bus.o_cntrl_push, epush);
            chk("cntrl_pop",  bus.o_cntrl_pop,  epop);
            if (epush) chk("mem_wdata", bus.o_mem_wdata, bus.i_cmd_data);
            if (bus.o_cntrl_push) push_cnt++;
            if (bus.o_cntrl_pop)  pop_cnt++;

            if (ev && bus.o_rsp_vld && bus.i_rsp_rdy) begin
                l.op = bus.o_rsp_op; l.err = bus.o_rsp_err; l.data = bus.o_rsp_data;
                l.lat = cyc - exp_q[0].acc_cyc; l.deq_cyc = cyc;
                rsp_log.push_back(l);
                void'(exp_q.pop_front());
            end
            if (acc) begin
                acc_cnt++;
                exp_q.push_back(e);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic issue(op_t op, logic [W-1:0] d);
        int n = 0;
        bus.i_cmd_vld  = 1'b1;
        bus.i_cmd_op   = op;
        bus.i_cmd_data = d;
        @(negedge clk);
        while (!bus.o_cmd_rdy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("issue_accept", bus.o_cmd_rdy, 1);
        @(posedge clk);
        #1;
        bus.i_cmd_vld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_log(string name, int idx, op_t op, logic err, logic [W-1:0] data);
        if (idx < rsp_log.size()) begin
            chk({name, "_op"},   rsp_log[idx].op,   op);
            chk({name, "_err"},  rsp_log[idx].err,  err);
            chk({name, "_data"}, rsp_log[idx].data, data);
        end else begin
            chk({name, "_present"}, 0, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, pbase, abase;
        logic [W-1:0] t3_data [5];
        logic [W-1:0] t5_data [6];
        op_t          t5_op   [6];

        bus.i_cmd_vld  = 1'b0;
        bus.i_cmd_op   = OP_PUSH;
        bus.i_cmd_data = '0;
        bus.i_rsp_rdy  = 1'b1;

        // 1. reset, then idle
        repeat (3) @(posedge clk);
        #1 arst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_cmd_rdy",  bus.o_cmd_rdy,    1);
        chk("t1_rsp_vld",  bus.o_rsp_vld,    0);
        chk("t1_push",     bus.o_cntrl_push, 0);
        chk("t1_pop",      bus.o_cntrl_pop,  0);
        chk("t1_rsp_data", bus.o_rsp_data,   0);
        chk("t1_rsp_err",  bus.o_rsp_err,    0);
        @(posedge clk);
        #1;

        // 2. five pushes into a four-entry stack
        base = rsp_log.size(); pbase = push_cnt;
        issue(OP_PUSH, 8'h11); issue(OP_PUSH, 8'h22); issue(OP_PUSH, 8'h33);
        issue(OP_PUSH, 8'h44); issue(OP_PUSH, 8'h55);
        drain();
        chk("t2_count", rsp_log.size() - base, 5);
        for (int i = 0; i < 5; i++) chk_log("t2", base + i, OP_PUSH, (i == 4), 8'h00);
        chk("t2_push_strobes", push_cnt - pbase, 4);

        // 3. five pops
        t3_data = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
        base = rsp_log.size(); pbase = pop_cnt;
        for (int i = 0; i < 5; i++) issue(OP_POP, 8'h00);
        drain();
        chk("t3_count", rsp_log.size() - base, 5);
        for (int i = 0; i < 5; i++) chk_log("t3", base + i, OP_POP, (i == 4), t3_data[i]);
        chk("t3_pop_strobes", pop_cnt - pbase, 4);

        // 4. alternate push 0xA5 / pop, full throughput
        base = rsp_log.size();
        issue(OP_PUSH, 8'hA5); issue(OP_POP, 8'h00);
        issue(OP_PUSH, 8'hA5); issue(OP_POP, 8'h00);
        drain();
        chk("t4_count", rsp_log.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk_log("t4", base + i, (i % 2) ? OP_POP : OP_PUSH, 1'b0, (i % 2) ? 8'hA5 : 8'h00);
            if (base + i < rsp_log.size()) begin
                chk("t4_latency", rsp_log[base+i].lat, 2);
                if (i > 0) chk("t4_back_to_back",
                               rsp_log[base+i].deq_cyc - rsp_log[base+i-1].deq_cyc, 1);
            end
        end

        // 5. back-pressure: six commands offered with i_rsp_rdy low
        t5_op   = '{OP_PUSH, OP_PUSH, OP_PUSH, OP_POP, OP_POP, OP_POP};
        t5_data = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h02, 8'h01};
        base = rsp_log.size(); abase = acc_cnt;
        bus.i_rsp_rdy = 1'b0;
        fork
            begin
                issue(OP_PUSH, 8'h01); issue(OP_PUSH, 8'h02); issue(OP_PUSH, 8'h03);
                issue(OP_POP, 8'h00);  issue(OP_POP, 8'h00);  issue(OP_POP, 8'h00);
            end
            begin
                repeat (8) @(negedge clk);
                chk("t5_rdy_low", bus.o_cmd_rdy, 0);
                chk("t5_accepts_stalled", acc_cnt - abase, 4);
                chk("t5_no_deq", rsp_log.size() - base, 0);
                bus.i_rsp_rdy = 1'b1;
            end
        join
        drain();
        chk("t5_accepts_total", acc_cnt - abase, 6);
        chk("t5_count", rsp_log.size() - base, 6);
        for (int i = 0; i < 6; i++) chk_log("t5", base + i, t5_op[i], 1'b0, t5_data[i]);

        // 6. reset with responses in flight and buffered
        base = rsp_log.size(); pbase = pop_cnt;
        bus.i_rsp_rdy = 1'b0;
        issue(OP_PUSH, 8'h66); issue(OP_PUSH, 8'h77); issue(OP_PUSH, 8'h88);
        chk("t6_pre_vld", bus.o_rsp_vld, 1);
        #1 arst_n = 1'b0;
        #1;
        chk("t6_rst_rsp_vld", bus.o_rsp_vld, 0);
        chk("t6_rst_cmd_rdy", bus.o_cmd_rdy, 1);
        chk("t6_rst_rsp_data", bus.o_rsp_data, 0);
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        bus.i_rsp_rdy = 1'b1;
        issue(OP_POP, 8'h00);
        drain();
        chk("t6_count", rsp_log.size() - base, 1);
        chk_log("t6", base, OP_POP, 1'b1, 8'h00);
        chk("t6_pop_strobes", pop_cnt - pbase, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
